// File: rtl/regfile_wb_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler_pkg
// Shared constants and types for the register-file write-back scheduler:
//   DEF_DATA_W / DEF_ADDR_W : default write-data and register-index widths
//   NUM_REGS                : number of architectural registers (32)
//   gnt_src_e               : which requester won the last arbitration
// ---------------------------------------------------------------------------
package regfile_wb_scheduler_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [0:0] {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } gnt_src_e;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler_if
// Bundles every non-clock/reset signal of the write-back scheduler.
//   alu_w*     : ALU write-back request / accept
//   mem_w*     : load-unit write-back request / accept
//   issue_*    : decode destination reservation handshake
//   rs/rt_*    : source-operand hazard queries
//   rf_*       : registered write port toward the register file
//   err_spurious : sticky flag, commit to a non-pending register
// Modports: slave = scheduler side, master = surrounding pipeline side.
// ---------------------------------------------------------------------------
interface regfile_wb_scheduler_if
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              alu_wvalid;
  logic [ADDR_W-1:0] alu_wreg;
  logic [DATA_W-1:0] alu_wdat;
  logic              alu_wready;

  logic              mem_wvalid;
  logic [ADDR_W-1:0] mem_wreg;
  logic [DATA_W-1:0] mem_wdat;
  logic              mem_wready;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_reg;
  logic              issue_ready;

  logic [ADDR_W-1:0] rs_reg;
  logic [ADDR_W-1:0] rt_reg;
  logic              rs_busy;
  logic              rt_busy;

  logic [ADDR_W-1:0] rf_wreg;
  logic [DATA_W-1:0] rf_wdat;
  logic              rf_write;
  logic              err_spurious;

  modport slave (
    input  alu_wvalid, alu_wreg, alu_wdat,
    input  mem_wvalid, mem_wreg, mem_wdat,
    input  issue_valid, issue_reg,
    input  rs_reg, rt_reg,
    output alu_wready, mem_wready, issue_ready,
    output rs_busy, rt_busy,
    output rf_wreg, rf_wdat, rf_write, err_spurious
  );

  modport master (
    output alu_wvalid, alu_wreg, alu_wdat,
    output mem_wvalid, mem_wreg, mem_wdat,
    output issue_valid, issue_reg,
    output rs_reg, rt_reg,
    input  alu_wready, mem_wready, issue_ready,
    input  rs_busy, rt_busy,
    input  rf_wreg, rf_wdat, rf_write, err_spurious
  );

endinterface

// File: rtl/regfile_wb_scheduler_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// Pending-write vector: one bit per register, set when decode reserves a
// destination, cleared when that register's data is committed to the file.
//   clk, reset          : clock, synchronous active-high reset
//   i_set_en/i_set_reg  : reserve a destination (register 0 ignored)
//   i_clr_en/i_clr_reg  : commit completes for a register
//   i_rs_reg/i_rt_reg   : source queries -> o_rs_busy/o_rt_busy
//   i_issue_reg         : issue lookup -> o_issue_busy
//   o_clr_busy          : pending state of the register being committed
// ---------------------------------------------------------------------------
module wb_scoreboard
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_REGS = NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_reg,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_reg,
  input  logic [ADDR_W-1:0] i_rs_reg,
  input  logic [ADDR_W-1:0] i_rt_reg,
  input  logic [ADDR_W-1:0] i_issue_reg,
  output logic              o_rs_busy,
  output logic              o_rt_busy,
  output logic              o_issue_busy,
  output logic              o_clr_busy
);

  localparam logic [N_REGS-1:0] ONE_HOT0 = {{(N_REGS-1){1'b0}}, 1'b1};

  logic [N_REGS-1:0] r_pending;
  logic [N_REGS-1:0] w_set_mask;
  logic [N_REGS-1:0] w_clr_mask;
  logic [N_REGS-1:0] w_pending_nxt;

  // Next pending vector; a set and a clear of different registers both apply,
  // and register 0 can never become pending.
  always_comb begin
    w_set_mask    = (i_set_en && (i_set_reg != {ADDR_W{1'b0}})) ?
                    (ONE_HOT0 << i_set_reg) : {N_REGS{1'b0}};
    w_clr_mask    = i_clr_en ? (ONE_HOT0 << i_clr_reg) : {N_REGS{1'b0}};
    w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
  end

  // Pending-vector register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= {N_REGS{1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Read ports see only the registered state, so a commit in flight still
  // reads as busy until its data has reached the file.
  assign o_rs_busy    = r_pending[i_rs_reg];
  assign o_rt_busy    = r_pending[i_rt_reg];
  assign o_issue_busy = r_pending[i_issue_reg];
  assign o_clr_busy   = r_pending[i_clr_reg];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
// Round-robin arbiter between ALU and load-unit write-backs feeding the single
// register-file write port through one register stage, plus the pending-write
// scoreboard used by decode for RAW/WAW stalls.
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : regfile_wb_scheduler_if.slave (requests, issue, queries, rf port)
// ---------------------------------------------------------------------------
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic                   clk,
  input logic                   reset,
  regfile_wb_scheduler_if.slave bus
);

  localparam int N_REGS = 32'd1 << ADDR_W;

  logic              w_alu_gnt;
  logic              w_mem_gnt;
  logic              w_any_gnt;
  logic [ADDR_W-1:0] w_gnt_reg;
  logic [DATA_W-1:0] w_gnt_dat;
  logic              w_issue_busy;
  logic              w_commit_busy;
  logic              w_set_en;

  gnt_src_e          r_last_grant;
  logic              r_rf_write;
  logic [ADDR_W-1:0] r_rf_wreg;
  logic [DATA_W-1:0] r_rf_wdat;
  logic              r_err_spurious;

  // Arbitration: on a conflict the source that did not win last time goes.
  always_comb begin
    if (bus.alu_wvalid && bus.mem_wvalid) begin
      w_alu_gnt = (r_last_grant == GNT_MEM);
      w_mem_gnt = (r_last_grant == GNT_ALU);
    end else begin
      w_alu_gnt = bus.alu_wvalid;
      w_mem_gnt = bus.mem_wvalid;
    end
    w_any_gnt = w_alu_gnt | w_mem_gnt;
  end

  // Select destination/data of the granted requester.
  always_comb begin
    if (w_alu_gnt) begin
      w_gnt_reg = bus.alu_wreg;
      w_gnt_dat = bus.alu_wdat;
    end else begin
      w_gnt_reg = bus.mem_wreg;
      w_gnt_dat = bus.mem_wdat;
    end
  end

  // Write-port stage. A grant to register 0 is consumed but never reaches the
  // file; address/data only change when a real write is launched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= GNT_MEM;
      r_rf_write   <= 1'b0;
      r_rf_wreg    <= {ADDR_W{1'b0}};
      r_rf_wdat    <= {DATA_W{1'b0}};
    end else begin
      if (w_any_gnt) begin
        r_last_grant <= w_alu_gnt ? GNT_ALU : GNT_MEM;
      end
      if (w_any_gnt && (w_gnt_reg != {ADDR_W{1'b0}})) begin
        r_rf_write <= 1'b1;
        r_rf_wreg  <= w_gnt_reg;
        r_rf_wdat  <= w_gnt_dat;
      end else begin
        r_rf_write <= 1'b0;
      end
    end
  end

  // Sticky error: a commit landed on a register nobody reserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_spurious <= 1'b0;
    end else if (r_rf_write && !w_commit_busy) begin
      r_err_spurious <= 1'b1;
    end
  end

  assign w_set_en = bus.issue_valid && !w_issue_busy &&
                    (bus.issue_reg != {ADDR_W{1'b0}});

  // Clearing on the commit cycle (not the grant cycle) keeps the register
  // busy until the file actually holds the new value.
  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .N_REGS (N_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .i_set_en     (w_set_en),
    .i_set_reg    (bus.issue_reg),
    .i_clr_en     (r_rf_write),
    .i_clr_reg    (r_rf_wreg),
    .i_rs_reg     (bus.rs_reg),
    .i_rt_reg     (bus.rt_reg),
    .i_issue_reg  (bus.issue_reg),
    .o_rs_busy    (bus.rs_busy),
    .o_rt_busy    (bus.rt_busy),
    .o_issue_busy (w_issue_busy),
    .o_clr_busy   (w_commit_busy)
  );

  assign bus.alu_wready   = w_alu_gnt;
  assign bus.mem_wready   = w_mem_gnt;
  assign bus.issue_ready  = !w_issue_busy;
  assign bus.rf_write     = r_rf_write;
  assign bus.rf_wreg      = r_rf_wreg;
  assign bus.rf_wdat      = r_rf_wdat;
  assign bus.err_spurious = r_err_spurious;

endmodule
